// File: rtl/io_port_arbiter.sv
// Round-robin arbiter sharing one I/O device req/ack channel between two requesters.
// Define IO_ARB_TIMEOUT_EN to bound the ack wait to TIMEOUT_CYCLES and raise a sticky timeout_o.
module io_port_arbiter #(
  parameter int D_WIDTH        = 34,
  parameter int PA_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                r0_req_i,
  input  logic                r0_we_i,
  input  logic [PA_WIDTH-1:0] r0_addr_i,
  input  logic [D_WIDTH-1:0]  r0_data_i,
  output logic                r0_done_o,
  output logic [D_WIDTH-1:0]  r0_data_o,
  input  logic                r1_req_i,
  input  logic                r1_we_i,
  input  logic [PA_WIDTH-1:0] r1_addr_i,
  input  logic [D_WIDTH-1:0]  r1_data_i,
  output logic                r1_done_o,
  output logic [D_WIDTH-1:0]  r1_data_o,
  output logic                io_read_req_o,
  output logic                io_write_req_o,
  output logic [PA_WIDTH-1:0] io_read_addr_o,
  output logic [PA_WIDTH-1:0] io_write_addr_o,
  output logic [D_WIDTH-1:0]  io_din_o,
  input  logic [D_WIDTH-1:0]  io_dout_i,
  input  logic                io_read_ack_i,
  input  logic                io_write_ack_i,
  output logic                busy_o,
  output logic                grant_o,
  output logic                timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t               state;
  logic                 ptr;
  logic                 we_q;
  logic                 r0_cand, r1_cand, any_cand, pick;
  logic                 sel_we;
  logic [PA_WIDTH-1:0]  sel_addr;
  logic [D_WIDTH-1:0]   sel_data;
  logic                 ack_match, tmo_hit, finish;
  logic [D_WIDTH-1:0]   fill_data;

  // A requester whose done is pulsing this cycle is not re-granted: it gets
  // one cycle to drop req, so a held req starts a fresh transaction only after that.
  assign r0_cand  = r0_req_i & ~r0_done_o;
  assign r1_cand  = r1_req_i & ~r1_done_o;
  assign any_cand = r0_cand | r1_cand;
  assign pick     = (r0_cand & r1_cand) ? ptr : r1_cand;

  assign sel_we   = pick ? r1_we_i   : r0_we_i;
  assign sel_addr = pick ? r1_addr_i : r0_addr_i;
  assign sel_data = pick ? r1_data_i : r0_data_i;

  assign ack_match = we_q ? io_write_ack_i : io_read_ack_i;
  assign finish    = (state == S_WAIT) & (ack_match | tmo_hit);
  assign fill_data = ack_match ? io_dout_i : '1;

`ifdef IO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // The counter reaches the limit on the edge closing the last allowed WAIT cycle.
  assign tmo_hit = (state == S_WAIT) & ~ack_match &
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (tmo_hit) timeout_o <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state           <= S_IDLE;
      ptr             <= 1'b0;
      we_q            <= 1'b0;
      grant_o         <= 1'b0;
      busy_o          <= 1'b0;
      io_read_req_o   <= 1'b0;
      io_write_req_o  <= 1'b0;
      io_read_addr_o  <= '0;
      io_write_addr_o <= '0;
      io_din_o        <= '0;
      r0_done_o       <= 1'b0;
      r1_done_o       <= 1'b0;
      r0_data_o       <= '0;
      r1_data_o       <= '0;
    end else begin
      // NOTE: pulse outputs default low here so every state only has to set them;
      // non-blocking assignment lets a later write in the same block override this.
      r0_done_o      <= 1'b0;
      r1_done_o      <= 1'b0;
      io_read_req_o  <= 1'b0;
      io_write_req_o <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (any_cand) begin
            grant_o         <= pick;
            we_q            <= sel_we;
            io_read_addr_o  <= sel_addr;
            io_write_addr_o <= sel_addr;
            io_din_o        <= sel_data;
            io_write_req_o  <= sel_we;
            io_read_req_o   <= ~sel_we;
            busy_o          <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (finish) begin
            if (grant_o) begin
              r1_done_o <= 1'b1;
              if (!we_q) r1_data_o <= fill_data;
            end else begin
              r0_done_o <= 1'b1;
              if (!we_q) r0_data_o <= fill_data;
            end
            ptr    <= ~grant_o;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed self-checking bench for io_port_arbiter with a small device responder.
// Timeout behaviour is exercised when IO_ARB_TIMEOUT_EN is defined.
module tb_io_port_arbiter;

  localparam int DW = 34;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          r0_req_i, r0_we_i, r1_req_i, r1_we_i;
  logic [AW-1:0] r0_addr_i, r1_addr_i;
  logic [DW-1:0] r0_data_i, r1_data_i;
  logic          r0_done_o, r1_done_o;
  logic [DW-1:0] r0_data_o, r1_data_o;
  logic          io_read_req_o, io_write_req_o;
  logic [AW-1:0] io_read_addr_o, io_write_addr_o;
  logic [DW-1:0] io_din_o, io_dout_i;
  logic          io_read_ack_i, io_write_ack_i;
  logic          busy_o, grant_o, timeout_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic          auto_ack;
  logic          rd_pend, wr_pend;
  logic [DW-1:0] dev_counter;

  io_port_arbiter dut (
    .clk(clk), .reset_i(reset_i),
    .r0_req_i(r0_req_i), .r0_we_i(r0_we_i), .r0_addr_i(r0_addr_i), .r0_data_i(r0_data_i),
    .r0_done_o(r0_done_o), .r0_data_o(r0_data_o),
    .r1_req_i(r1_req_i), .r1_we_i(r1_we_i), .r1_addr_i(r1_addr_i), .r1_data_i(r1_data_i),
    .r1_done_o(r1_done_o), .r1_data_o(r1_data_o),
    .io_read_req_o(io_read_req_o), .io_write_req_o(io_write_req_o),
    .io_read_addr_o(io_read_addr_o), .io_write_addr_o(io_write_addr_o),
    .io_din_o(io_din_o), .io_dout_i(io_dout_i),
    .io_read_ack_i(io_read_ack_i), .io_write_ack_i(io_write_ack_i),
    .busy_o(busy_o), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Device: address 2 is a counter, other addresses return {addr, fixed pattern}.
  function automatic logic [DW-1:0] dev_data(input logic [AW-1:0] a);
    if (a == 4'd2) return dev_counter;
    return {a, 30'h0ABC_DEF};
  endfunction

  // Advance one cycle and sample 1 time unit after the edge; the auto responder
  // acks one cycle after it sees an io request.
  task automatic tick();
    @(posedge clk); #1;
    if (auto_ack) begin
      io_read_ack_i  = rd_pend;
      io_write_ack_i = wr_pend;
      if (rd_pend) begin
        io_dout_i = dev_data(io_read_addr_o);
        if (io_read_addr_o == 4'd2) dev_counter = dev_counter + 1;
      end
      rd_pend = io_read_req_o;
      wr_pend = io_write_req_o;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    r0_req_i = 0; r0_we_i = 0; r0_addr_i = '0; r0_data_i = '0;
    r1_req_i = 0; r1_we_i = 0; r1_addr_i = '0; r1_data_i = '0;
    io_dout_i = '0; io_read_ack_i = 0; io_write_ack_i = 0;
    auto_ack = 0; rd_pend = 0; wr_pend = 0;
    @(posedge clk); #1;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    do_reset();
    ctl = {r0_done_o, r1_done_o, io_read_req_o, io_write_req_o, busy_o, grant_o, timeout_o, 1'b0};
    n_cmp++; if (ctl !== 8'h00) begin n_fail++; $display("FAIL reset_ctl: got %h want 00", ctl); end
    n_cmp++; if ({r0_data_o, r1_data_o, io_din_o} !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want 0", r0_data_o, r1_data_o, io_din_o); end
    n_cmp++; if ({io_read_addr_o, io_write_addr_o} !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h %h want 0", io_read_addr_o, io_write_addr_o); end
  endtask

  task automatic test_single_read();
    auto_ack = 1; rd_pend = 0; wr_pend = 0;
    r0_req_i = 1; r0_we_i = 0; r0_addr_i = 4'd2;
    tick();  // cycle 1
    n_cmp++; if ({io_read_req_o, io_write_req_o} !== 2'b10) begin n_fail++; $display("FAIL rd_issue_req: got %b want 10", {io_read_req_o, io_write_req_o}); end
    n_cmp++; if (io_read_addr_o !== 4'd2) begin n_fail++; $display("FAIL rd_issue_addr: got %h want 2", io_read_addr_o); end
    n_cmp++; if ({busy_o, grant_o} !== 2'b10) begin n_fail++; $display("FAIL rd_busy_grant: got %b want 10", {busy_o, grant_o}); end
    tick();  // cycle 2
    n_cmp++; if ({io_read_req_o, r0_done_o} !== 2'b00) begin n_fail++; $display("FAIL rd_wait: got %b want 00", {io_read_req_o, r0_done_o}); end
    tick();  // cycle 3
    n_cmp++; if ({r0_done_o, r1_done_o, busy_o} !== 3'b100) begin n_fail++; $display("FAIL rd_done: got %b want 100", {r0_done_o, r1_done_o, busy_o}); end
    n_cmp++; if (r0_data_o !== 34'h1_2345_6789) begin n_fail++; $display("FAIL rd_data: got %h want 123456789", r0_data_o); end
    r0_req_i = 0;
    tick();  // cycle 4
    n_cmp++; if ({r0_done_o, busy_o, io_read_req_o} !== 3'b000) begin n_fail++; $display("FAIL rd_after: got %b want 000", {r0_done_o, busy_o, io_read_req_o}); end
    auto_ack = 0; io_read_ack_i = 0; io_write_ack_i = 0;
  endtask

  task automatic test_single_write();
    auto_ack = 1; rd_pend = 0; wr_pend = 0;
    r1_req_i = 1; r1_we_i = 1; r1_addr_i = 4'd3; r1_data_i = 34'h2A;
    tick();
    n_cmp++; if ({io_read_req_o, io_write_req_o} !== 2'b01) begin n_fail++; $display("FAIL wr_issue_req: got %b want 01", {io_read_req_o, io_write_req_o}); end
    n_cmp++; if ({io_write_addr_o, io_din_o} !== {4'd3, 34'h2A}) begin n_fail++; $display("FAIL wr_issue_addr_din: got %h %h want 3 2a", io_write_addr_o, io_din_o); end
    n_cmp++; if (grant_o !== 1'b1) begin n_fail++; $display("FAIL wr_grant: got %b want 1", grant_o); end
    tick();
    n_cmp++; if ({io_write_req_o, r1_done_o} !== 2'b00) begin n_fail++; $display("FAIL wr_wait: got %b want 00", {io_write_req_o, r1_done_o}); end
    tick();
    n_cmp++; if ({r1_done_o, r0_done_o} !== 2'b10) begin n_fail++; $display("FAIL wr_done: got %b want 10", {r1_done_o, r0_done_o}); end
    n_cmp++; if (r1_data_o !== '0) begin n_fail++; $display("FAIL wr_data_kept: got %h want 0", r1_data_o); end
    r1_req_i = 0; r1_we_i = 0;
    tick();
    auto_ack = 0; io_read_ack_i = 0; io_write_ack_i = 0;
  endtask

  task automatic test_wrong_ack();
    r0_req_i = 1; r0_we_i = 0; r0_addr_i = 4'd6;
    tick();  // ISSUE
    tick();  // WAIT: wrong-type ack
    io_write_ack_i = 1;
    tick();
    io_write_ack_i = 0;
    n_cmp++; if ({r0_done_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL wrong_ack_ignored: got %b want 01", {r0_done_o, busy_o}); end
    io_read_ack_i = 1; io_dout_i = 34'h2_DEAD_BEEF;
    tick();
    io_read_ack_i = 0; r0_req_i = 0;
    n_cmp++; if ({r0_done_o, r0_data_o} !== {1'b1, 34'h2_DEAD_BEEF}) begin n_fail++; $display("FAIL wrong_ack_then_right: got %b %h want 1 2deadbeef", r0_done_o, r0_data_o); end
    tick();  // idle: spurious acks of both kinds
    io_read_ack_i = 1; io_write_ack_i = 1; io_dout_i = 34'h1_1111_1111;
    tick();
    io_read_ack_i = 0; io_write_ack_i = 0;
    n_cmp++; if ({r0_done_o, r1_done_o, busy_o, io_read_req_o, io_write_req_o} !== 5'b0) begin n_fail++; $display("FAIL spurious_ack: got %b want 00000", {r0_done_o, r1_done_o, busy_o, io_read_req_o, io_write_req_o}); end
    n_cmp++; if (r0_data_o !== 34'h2_DEAD_BEEF) begin n_fail++; $display("FAIL spurious_ack_data: got %h want 2deadbeef", r0_data_o); end
  endtask

  task automatic test_contention();
    do_reset();
    auto_ack = 1;
    r0_req_i = 1; r0_we_i = 0; r0_addr_i = 4'd2;
    r1_req_i = 1; r1_we_i = 0; r1_addr_i = 4'd5;
    for (int c = 1; c <= 11; c++) begin
      tick();
      n_cmp++; if (io_read_req_o && io_write_req_o) begin n_fail++; $display("FAIL both_io_req cycle %0d: got 11 want not both", c); end
      n_cmp++; if ({r0_done_o, r1_done_o} !== {(c == 3 || c == 9), (c == 6)}) begin n_fail++; $display("FAIL cont_done cycle %0d: got %b want %b", c, {r0_done_o, r1_done_o}, {(c == 3 || c == 9), (c == 6)}); end
      if (c == 1) begin n_cmp++; if (grant_o !== 1'b0) begin n_fail++; $display("FAIL cont_first_grant: got %b want 0", grant_o); end end
      if (c == 4) begin n_cmp++; if (grant_o !== 1'b1) begin n_fail++; $display("FAIL cont_second_grant: got %b want 1", grant_o); end end
      if (c == 6) begin n_cmp++; if (r1_data_o !== 34'h1_40AB_CDEF) begin n_fail++; $display("FAIL cont_r1_data: got %h want 140abcdef", r1_data_o); end end
      if (c == 9) begin
        n_cmp++; if (r0_data_o !== 34'h1_2345_678A) begin n_fail++; $display("FAIL cont_r0_data: got %h want 12345678a", r0_data_o); end
        r0_req_i = 0; r1_req_i = 0;
      end
    end
    auto_ack = 0; io_read_ack_i = 0; io_write_ack_i = 0;
  endtask

  task automatic test_reset_in_wait();
    r1_req_i = 1; r1_we_i = 0; r1_addr_i = 4'd7;
    tick();
    n_cmp++; if (io_read_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_issue: got %b want 1", io_read_req_o); end
    tick();  // WAIT
    #3 reset_i = 1'b1;
    #1;
    n_cmp++; if ({busy_o, grant_o, r1_done_o, io_read_req_o} !== 4'b0) begin n_fail++; $display("FAIL rst_async_ctl: got %b want 0000", {busy_o, grant_o, r1_done_o, io_read_req_o}); end
    n_cmp++; if ({r1_data_o, io_read_addr_o} !== '0) begin n_fail++; $display("FAIL rst_async_data: got %h %h want 0", r1_data_o, io_read_addr_o); end
    @(posedge clk); #1;
    n_cmp++; if (r1_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got %b want 0", r1_done_o); end
    reset_i = 1'b0;
    tick();
    n_cmp++; if ({io_read_req_o, grant_o, busy_o, io_read_addr_o} !== {3'b111, 4'd7}) begin n_fail++; $display("FAIL rst_regrant: got %b %h want 111 7", {io_read_req_o, grant_o, busy_o}, io_read_addr_o); end
    tick();
    io_read_ack_i = 1; io_dout_i = 34'h0_0000_0077;
    tick();
    io_read_ack_i = 0; r1_req_i = 0;
    n_cmp++; if ({r1_done_o, r1_data_o} !== {1'b1, 34'h77}) begin n_fail++; $display("FAIL rst_complete: got %b %h want 1 77", r1_done_o, r1_data_o); end
    tick();
  endtask

  task automatic test_timeout();
    r0_req_i = 1; r0_we_i = 0; r0_addr_i = 4'd2;
    tick();  // cycle 1: ISSUE
`ifdef IO_ARB_TIMEOUT_EN
    for (int c = 2; c <= 17; c++) begin
      tick();
      n_cmp++; if ({r0_done_o, timeout_o} !== 2'b00) begin n_fail++; $display("FAIL tmo_early cycle %0d: got %b want 00", c, {r0_done_o, timeout_o}); end
    end
    tick();  // cycle 18
    n_cmp++; if ({r0_done_o, timeout_o, busy_o} !== 3'b110) begin n_fail++; $display("FAIL tmo_fire: got %b want 110", {r0_done_o, timeout_o, busy_o}); end
    n_cmp++; if (r0_data_o !== 34'h3_FFFF_FFFF) begin n_fail++; $display("FAIL tmo_data: got %h want 3ffffffff", r0_data_o); end
    r0_req_i = 0;
    tick(); tick();
    n_cmp++; if ({r0_done_o, timeout_o} !== 2'b01) begin n_fail++; $display("FAIL tmo_sticky: got %b want 01", {r0_done_o, timeout_o}); end
    do_reset();
    n_cmp++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL tmo_cleared: got %b want 0", timeout_o); end
`else
    for (int c = 2; c <= 25; c++) begin
      tick();
      n_cmp++; if ({r0_done_o, busy_o, timeout_o} !== 3'b010) begin n_fail++; $display("FAIL wait_forever cycle %0d: got %b want 010", c, {r0_done_o, busy_o, timeout_o}); end
    end
    io_read_ack_i = 1; io_dout_i = 34'h0_0000_0123;
    tick();
    io_read_ack_i = 0; r0_req_i = 0;
    n_cmp++; if ({r0_done_o, r0_data_o} !== {1'b1, 34'h123}) begin n_fail++; $display("FAIL late_ack: got %b %h want 1 123", r0_done_o, r0_data_o); end
    tick();
`endif
  endtask

  initial begin
    dev_counter = 34'h1_2345_6789;
    test_reset();
    test_single_read();
    test_single_write();
    test_wrong_ack();
    dev_counter = 34'h1_2345_6789;
    test_contention();
    test_reset_in_wait();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
